muldiv_unit: RTL

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU over multiple cycles. It exports busy so the hazard unit can drive the en/clear inputs of the IF/ID and ID/EX pipeline registers for MFHI/MFLO stalls. MTHI/MTLO complete in one cycle.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_signfix.sv | 23 ++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and counter sizing.
package muldiv_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CW = cnt_width(W_DEFAULT);

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational two's-complement sign correction applied to the unsigned
// magnitude results (2W product, quotient, remainder) in the FIX state.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [2*W-1:0] i_prod,
  input  logic           i_neg_prod,
  input  logic [W-1:0]   i_quot,
  input  logic           i_neg_quot,
  input  logic [W-1:0]   i_rem,
  input  logic           i_neg_rem,
  output logic [2*W-1:0] o_prod,
  output logic [W-1:0]   o_quot,
  output logic [W-1:0]   o_rem
);

  assign o_prod = i_neg_prod ? -i_prod : i_prod;
  assign o_quot = i_neg_quot ? -i_quot : i_quot;
  assign o_rem  = i_neg_rem  ? -i_rem  : i_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shift-add or
// restoring-subtract step per cycle on operand magnitudes, signs fixed at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CNT_W = (W == W_DEFAULT) ? CW : cnt_width(W);

  if ((W < 4) || ((W % 2) != 0)) begin : g_bad_w
    $error("muldiv_unit: W must be even and at least 4");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*W-1:0]     r_prod;
  logic [W-1:0]       r_opnd;
  logic [W-1:0]       r_hi;
  logic [W-1:0]       r_lo;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_done;

  logic               w_issue;
  logic               w_step;
  logic               w_fix;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_last;
  logic               w_signed_op;
  logic               w_is_div_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [W-1:0]       w_a_mag;
  logic [W-1:0]       w_b_mag;

  logic [W:0]         w_sum;
  logic [2*W-1:0]     w_mul_next;
  logic [W:0]         w_rem_sh;
  logic               w_ge;
  logic [W-1:0]       w_diff;
  logic [2*W-1:0]     w_div_next;

  logic [2*W-1:0]     w_prod_fix;
  logic [W-1:0]       w_quot_fix;
  logic [W-1:0]       w_rem_fix;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_last = (r_cnt == CNT_W'(W - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start && !flush && !op[2]) w_state_next = CALC;
      CALC:    if (flush)       w_state_next = IDLE;
               else if (w_last) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_mthi  = 1'b0;
    w_mtlo  = 1'b0;
    w_step  = 1'b0;
    w_fix   = 1'b0;
    case (r_state)
      IDLE: begin
        w_issue = start && !flush && !op[2];
        w_mthi  = start && !flush && (op == OP_MTHI);
        w_mtlo  = start && !flush && (op == OP_MTLO);
      end
      CALC:    w_step = !flush;
      FIX:     w_fix  = !flush;
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);

  // ---------------- operand conditioning ----------------
  assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div_op = op[1];
  assign w_a_neg     = w_signed_op && a[W-1];
  assign w_b_neg     = w_signed_op && b[W-1];
  assign w_a_mag     = w_a_neg ? -a : a;
  assign w_b_mag     = w_b_neg ? -b : b;

  // Multiply: r_prod = {accumulator, remaining multiplier bits}
  assign w_sum      = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_mul_next = {w_sum, r_prod[W-1:1]};

  // Divide: r_prod = {partial remainder, dividend bits shifting into quotient}
  assign w_rem_sh   = {r_prod[2*W-1:W], r_prod[W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = w_rem_sh[W-1:0] - r_opnd;
  assign w_div_next = {(w_ge ? w_diff : w_rem_sh[W-1:0]), r_prod[W-2:0], w_ge};

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_issue) begin
      r_cnt    <= '0;
      r_prod   <= {{W{1'b0}}, (w_is_div_op ? w_a_mag : w_b_mag)};
      r_opnd   <= w_is_div_op ? w_b_mag : w_a_mag;
      r_is_div <= w_is_div_op;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_div0   <= w_is_div_op && (b == '0);
    end else if (w_step) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_prod   <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  muldiv_signfix #(.W(W)) u_signfix (
    .i_prod     (r_prod),
    .i_neg_prod (r_neg_q),
    .i_quot     (r_prod[W-1:0]),
    .i_neg_quot (r_neg_q),
    .i_rem      (r_prod[2*W-1:W]),
    .i_neg_rem  (r_neg_r),
    .o_prod     (w_prod_fix),
    .o_quot     (w_quot_fix),
    .o_rem      (w_rem_fix)
  );

  // Divide by zero leaves |a| as the remainder, so the dividend-sign fix
  // already restores the raw a for HI; only LO needs overriding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= r_div0 ? {W{1'b1}} : w_quot_fix;
        end else begin
          {r_hi, r_lo} <= w_prod_fix;
        end
      end else begin
        if (w_mthi) r_hi <= a;
        if (w_mtlo) r_lo <= a;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule
